led_cmd_ctrl: RTL and testbench

Front-panel command controller for the 8-bit LED counter datapath. It debounces the four board push-buttons and turns presses into single-cycle clear, increment and decrement commands. It also runs an auto-stepping mode that clocks the counter up or down at a fixed rate. It sits between the raw button pins and the counter register, so the counter only ever sees clean, mutually exclusive one-cycle commands.

---
 rtl/led_cmd_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_cmd_ctrl.sv
// Front-panel command controller: debounces four push-buttons, arbitrates presses
// and drives one-cycle clear/inc/dec commands plus an auto-stepping run mode.

module led_btn_deb #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic CLK_50M,
  input  logic RST,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          s1, s2, db, db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      db_prev <= db;
      // any sample that agrees with db restarts the qualification window
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_prev;
endmodule

module led_cmd_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic CLK_50M,
  input  logic RST,
  input  logic BTN_NORTH,
  input  logic BTN_SOUTH,
  input  logic BTN_EAST,
  input  logic BTN_WEST,
  output logic cnt_clr,
  output logic cnt_inc,
  output logic cnt_dec,
  output logic run,
  output logic dir
);
  localparam int NUM_BTN = 4;
  localparam int BN = 0, BS = 1, BE = 2, BW = 3;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;

  logic [NUM_BTN-1:0] btn, press;
  state_t             st, st_nxt;
  logic [TW-1:0]      tmr, tmr_nxt;
  logic               clr_nxt, inc_nxt, dec_nxt, step_ok, tc;

  assign btn = {BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH};

  led_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .CLK_50M (CLK_50M),
    .RST     (RST),
    .btn     (btn),
    .press   (press)
  );

  always_comb begin
    st_nxt  = st;
    tmr_nxt = tmr;
    clr_nxt = 1'b0;
    inc_nxt = 1'b0;
    dec_nxt = 1'b0;
    step_ok = 1'b0;
    tc      = (st != IDLE) && (tmr == TMAX);

    // fixed priority SOUTH > WEST > NORTH > EAST; a losing press is simply dropped
    if (press[BS]) begin
      clr_nxt = 1'b1;
      st_nxt  = IDLE;
    end else if (press[BW]) begin
      case (st)
        IDLE:    st_nxt = RUN_UP;
        RUN_UP:  st_nxt = RUN_DN;
        default: st_nxt = IDLE;
      endcase
    end else if (press[BN]) begin
      if (st == IDLE)        inc_nxt = 1'b1;
      else if (st == RUN_DN) st_nxt  = RUN_UP;
      else                   step_ok = 1'b1;
    end else if (press[BE]) begin
      if (st == IDLE)        dec_nxt = 1'b1;
      else if (st == RUN_UP) st_nxt  = RUN_DN;
      else                   step_ok = 1'b1;
    end else begin
      step_ok = 1'b1;
    end

    if (step_ok && tc) begin
      inc_nxt = (st == RUN_UP);
      dec_nxt = (st == RUN_DN);
    end

    if (st_nxt != st || st_nxt == IDLE) tmr_nxt = '0;
    else if (tmr == TMAX)               tmr_nxt = '0;
    else                                tmr_nxt = tmr + 1'b1;
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      st      <= IDLE;
      tmr     <= '0;
      cnt_clr <= 1'b0;
      cnt_inc <= 1'b0;
      cnt_dec <= 1'b0;
      run     <= 1'b0;
      dir     <= 1'b0;
    end else begin
      st      <= st_nxt;
      tmr     <= tmr_nxt;
      cnt_clr <= clr_nxt;
      cnt_inc <= inc_nxt;
      cnt_dec <= dec_nxt;
      run     <= (st_nxt != IDLE);
      dir     <= (st_nxt == RUN_DN);
    end
  end
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Bench for led_cmd_ctrl: scoreboard of expected command pulses (kind + cycle)
// plus a behavioural 8-bit counter driven by the command outputs.
`timescale 1ns/1ps

module tb_led_cmd_ctrl;
  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam logic [1:0] K_NONE = 2'd0, K_CLR = 2'd1, K_INC = 2'd2, K_DEC = 2'd3;
  localparam logic [3:0] M_N = 4'b0001, M_S = 4'b0010, M_E = 4'b0100, M_W = 4'b1000;

  logic CLK_50M = 1'b0;
  logic RST = 1'b1;
  logic BTN_NORTH = 1'b0, BTN_SOUTH = 1'b0, BTN_EAST = 1'b0, BTN_WEST = 1'b0;
  logic cnt_clr, cnt_inc, cnt_dec, run, dir;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] count;

  typedef struct {logic [1:0] kind; int at;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] mon_k;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] kind;
    logic       exp_run;
    logic       exp_dir;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vecs[7];

  led_cmd_ctrl #(.DEB_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
    .CLK_50M   (CLK_50M),
    .RST       (RST),
    .BTN_NORTH (BTN_NORTH),
    .BTN_SOUTH (BTN_SOUTH),
    .BTN_EAST  (BTN_EAST),
    .BTN_WEST  (BTN_WEST),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc),
    .cnt_dec   (cnt_dec),
    .run       (run),
    .dir       (dir)
  );

  always #10 CLK_50M = ~CLK_50M;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  always @(posedge CLK_50M or posedge RST) begin
    if (RST)          count <= 8'h00;
    else if (cnt_clr) count <= 8'h00;
    else if (cnt_inc) count <= count + 8'h01;
    else if (cnt_dec) count <= count - 8'h01;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] k, input int at);
    sb.push_back('{kind: k, at: at});
  endtask

  task automatic set_btn(input logic [3:0] m);
    {BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH} = m;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK_50M);
  endtask

  // Drive mask so its command lands in cycle t (first sample at t-6, output at t);
  // hold 8 cycles, release, return at the negedge of cycle t+1.
  task automatic press_at(input logic [3:0] m, input int t);
    if (cyc > t - 7) begin
      checks++;
      failures++;
      $display("FAIL schedule: cycle %0d already past drive point %0d", cyc, t - 7);
    end
    wait_until(t - 7);
    set_btn(m);
    repeat (8) @(negedge CLK_50M);
    set_btn(4'b0000);
  endtask

  // every command pulse must match the head of the scoreboard in kind and cycle
  always @(negedge CLK_50M) begin
    if (cnt_clr | cnt_inc | cnt_dec) begin
      mon_k = cnt_clr ? K_CLR : (cnt_inc ? K_INC : K_DEC);
      check("exclusive", $countones({cnt_clr, cnt_inc, cnt_dec}), 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", mon_k, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", int'(mon_k), int'(mon_e.kind));
        check("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, e, e2, e3, e4, e5, r;
    int glitch[6];
    vecs[0] = '{M_E,             K_DEC,  1'b0, 1'b0, 8'h00};
    vecs[1] = '{M_E,             K_DEC,  1'b0, 1'b0, 8'hFF};
    vecs[2] = '{M_N,             K_INC,  1'b0, 1'b0, 8'h00};
    vecs[3] = '{M_N,             K_INC,  1'b0, 1'b0, 8'h01};
    vecs[4] = '{M_N|M_S|M_E|M_W, K_CLR,  1'b0, 1'b0, 8'h00};
    vecs[5] = '{M_S,             K_CLR,  1'b0, 1'b0, 8'h00};
    vecs[6] = '{M_W|M_N,         K_NONE, 1'b1, 1'b0, 8'h00};
    glitch  = '{1, 1, 2, 2, 3, 1};
    e = 0;

    // reset: asynchronous assertion clears outputs before the next edge
    repeat (2) @(negedge CLK_50M);
    RST = 1'b0;
    repeat (3) @(negedge CLK_50M);
    @(posedge CLK_50M);
    #5 RST = 1'b1;
    #2 check("rst_async_outputs", int'({cnt_clr, cnt_inc, cnt_dec, run, dir}), 0);
    repeat (2) @(negedge CLK_50M);
    RST = 1'b0;
    repeat (50) @(negedge CLK_50M);
    check("idle_no_pulses", sb.size(), 0);
    check("idle_run", int'(run), 0);
    check("idle_count", int'(count), 8'h00);

    // bounce filtering on NORTH: glitches of 1..3 cycles, then a stable press
    for (int i = 0; i < 6; i++) begin
      BTN_NORTH = (i % 2 == 0);
      repeat (glitch[i]) @(negedge CLK_50M);
    end
    BTN_NORTH = 1'b1;
    expect_pulse(K_INC, cyc + 7);
    repeat (10) @(negedge CLK_50M);
    BTN_NORTH = 1'b0;
    repeat (20) @(negedge CLK_50M);
    check("bounce_all_seen", sb.size(), 0);
    check("bounce_count", int'(count), 8'h01);

    // table vectors from IDLE; the last one starts RUN_UP
    for (int i = 0; i < 7; i++) begin
      t = cyc + 8;
      if (vecs[i].kind != K_NONE) expect_pulse(vecs[i].kind, t);
      if (vecs[i].exp_run)
        for (int k = 1; k <= 3; k++) expect_pulse(K_INC, t + STEP * k);
      press_at(vecs[i].btn, t);
      @(negedge CLK_50M);
      check("vec_run", int'(run), int'(vecs[i].exp_run));
      check("vec_dir", int'(dir), int'(vecs[i].exp_dir));
      check("vec_count", int'(count), int'(vecs[i].exp_cnt));
      e = t;
      if (!vecs[i].exp_run) wait_until(t + 8);
    end

    // run sequence: three up-steps, EAST flips direction, WEST returns to IDLE
    e2 = e + 28;
    expect_pulse(K_DEC, e2 + STEP);
    expect_pulse(K_DEC, e2 + 2 * STEP);
    press_at(M_E, e2);
    @(negedge CLK_50M);
    check("runup_count_3", int'(count), 8'h03);
    check("rundn_run", int'(run), 1);
    check("rundn_dir", int'(dir), 1);
    e3 = e2 + 20;
    press_at(M_W, e3);
    @(negedge CLK_50M);
    check("stop_run", int'(run), 0);
    check("stop_dir", int'(dir), 0);
    check("stop_count", int'(count), 8'h01);
    wait_until(e3 + 40);
    check("stop_no_pulses", sb.size(), 0);
    check("stop_count_held", int'(count), 8'h01);

    // collision: SOUTH debounces on the step timer's terminal cycle
    e4 = cyc + 8;
    expect_pulse(K_INC, e4 + STEP);
    expect_pulse(K_CLR, e4 + 2 * STEP);
    press_at(M_W, e4);
    press_at(M_S, e4 + 2 * STEP);
    @(negedge CLK_50M);
    check("coll_run", int'(run), 0);
    check("coll_count", int'(count), 8'h00);
    wait_until(e4 + 40);
    check("coll_no_pulses", sb.size(), 0);
    check("coll_count_held", int'(count), 8'h00);

    // reset mid-step with NORTH held: held button is re-seen as a press
    e5 = cyc + 8;
    expect_pulse(K_INC, e5 + STEP);
    press_at(M_W, e5);
    wait_until(e5 + 9);
    BTN_NORTH = 1'b1;
    wait_until(e5 + 11);
    check("pre_rst_run", int'(run), 1);
    @(posedge CLK_50M);
    #5 RST = 1'b1;
    #2 check("mid_rst_run_async", int'(run), 0);
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    RST = 1'b0;
    r = cyc;
    expect_pulse(K_INC, r + 7);
    wait_until(r + 9);
    check("post_rst_run", int'(run), 0);
    check("post_rst_count", int'(count), 8'h01);
    wait_until(r + 40);
    check("post_rst_no_pulses", sb.size(), 0);
    check("post_rst_count_held", int'(count), 8'h01);
    BTN_NORTH = 1'b0;
    repeat (10) @(negedge CLK_50M);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
